// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store replication, load extension
// and misaligned/illegal detection for one RV32I load/store.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_steer,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [31:0] rdata_sh;
  logic        illegal;
  logic        misaligned;

  assign rdata_sh = rdata >> {addr, 3'b000};

  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    if (write) begin
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    end else begin
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                  funct3 == F3_BU || funct3 == F3_HU);
    end
    if (funct3[1:0] == 2'b01) misaligned = addr[0];
    if (funct3[1:0] == 2'b10) misaligned = (addr != 2'b00);
  end

  assign bad = illegal || misaligned;

  always_comb begin
    be          = 4'b1111;
    wdata_steer = wdata;
    if (write) begin
      case (funct3)
        F3_B: begin
          be          = 4'b0001 << addr;
          wdata_steer = {4{wdata[7:0]}};
        end
        F3_H: begin
          be          = addr[1] ? 4'b1100 : 4'b0011;
          wdata_steer = {2{wdata[15:0]}};
        end
        default: begin
          be          = 4'b1111;
          wdata_steer = wdata;
        end
      endcase
    end
  end

  always_comb begin
    rdata_ext = 32'd0;
    case (funct3)
      F3_B:    rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_BU:   rdata_ext = {24'd0, rdata_sh[7:0]};
      F3_H:    rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_HU:   rdata_ext = {16'd0, rdata_sh[15:0]};
      F3_W:    rdata_ext = rdata_sh;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses
// with a fixed MEM_LATENCY strobe window and a one-cycle response pulse.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory strobe held, wait counter running
// RESP   | good response pulse
// ERR    | error response pulse, memory untouched
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

  lsu_state_t  state;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;

  logic        write_sel;
  logic [2:0]  funct3_sel;
  logic [1:0]  addr_sel;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;
  logic        bad_c;

  // Decode the live request while idle, the latched one while the access runs.
  assign write_sel  = (state == IDLE) ? req_write       : write_q;
  assign funct3_sel = (state == IDLE) ? req_funct3      : funct3_q;
  assign addr_sel   = (state == IDLE) ? req_addr[1:0]   : addr_q;

  assign req_ready = (state == IDLE) && !rst;

  lsu_lane_align u_lane_align (
    .write       (write_sel),
    .funct3      (funct3_sel),
    .addr        (addr_sel),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (be_c),
    .wdata_steer (wdata_c),
    .rdata_ext   (rdata_c),
    .bad         (bad_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      write_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 2'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[1:0];
            if (bad_c) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              wait_cnt  <= WAIT_INIT;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_read  <= !req_write;
              mem_write <= req_write;
              mem_be    <= be_c;
              mem_wdata <= req_write ? wdata_c : 32'd0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state      <= RESP;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= write_q ? 32'd0 : rdata_c;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (latency 1 and 3), directed lane and
// error cases, back-to-back, reset mid-access, then random traffic vs. a model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_err   [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [3:0]  mem_be     [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [31:0] mem_rdata  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(resp_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  load_store_unit #(.MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(resp_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: access size in bytes, legality, lanes computed arithmetically.
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bit err, output logic [3:0] be,
                                output logic [31:0] mwd, output logic [31:0] res);
    int size;
    int a;
    bit legal;
    longint unsigned mask;
    longint unsigned v;
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    legal = (size != 0) && (wr ? !f3[2] : !(f3[2] && size == 4));
    a = int'(addr % 4);
    err = !legal;
    if (legal && (a % size) != 0) err = 1'b1;
    be = 4'hF;
    mwd = 32'd0;
    res = 32'd0;
    if (!err) begin
      if (wr) begin
        be = 4'(((1 << size) - 1) << a);
        for (int b = 0; b < 4; b++) mwd[8*b +: 8] = wdata[8*(b % size) +: 8];
      end else begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v = (64'(rdata) >> (8 * a)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        res = v[31:0];
      end
    end
  endfunction

  task automatic wait_ready(input int d);
    int n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic run_txn(input int d, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    bit err;
    logic [3:0] be;
    logic [31:0] mwd;
    logic [31:0] res;
    int cyc = 0;
    int strobes = 0;
    bit seen = 0;
    model(wr, f3, addr, wdata, rdata, err, be, mwd, res);
    wait_ready(d);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    mem_rdata[d]  = rdata;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_read[d] || mem_write[d]) begin
        strobes++;
        check("mem_addr", mem_addr[d], {addr[31:2], 2'b00});
        check("mem_be", 32'(mem_be[d]), 32'(be));
        check("mem_write", 32'(mem_write[d]), 32'(wr));
        check("mem_read", 32'(mem_read[d]), 32'(!wr));
        if (wr) check("mem_wdata", mem_wdata[d], mwd);
      end
      if (resp_valid[d]) begin
        seen = 1;
        check("resp_lat", 32'(cyc), err ? 32'd1 : 32'(lat_of(d) + 1));
        check("resp_err", 32'(resp_err[d]), 32'(err));
        check("resp_rdata", resp_rdata[d], res);
      end
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("strobe_cycles", 32'(strobes), err ? 32'd0 : 32'(lat_of(d)));
    @(negedge clk);
    check("resp_pulse_end", 32'(resp_valid[d]), 32'd0);
    check("ready_after", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    int rd_cnt;
    int rdy_cnt;
    int rv_cnt;
    bit err;
    logic [3:0] be;
    logic [31:0] mwd;
    logic [31:0] res;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; mem_rdata[d] = 32'd0;
    end
    #1 rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd0);
      check("rst_resp", {29'd0, resp_valid[d], resp_err[d], mem_read[d] | mem_write[d]}, 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_mem", mem_addr[d] | mem_wdata[d] | 32'(mem_be[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_post_rst", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    run_txn(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
    run_txn(0, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8070_F0A5);
    run_txn(0, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h8070_F0A5);
    run_txn(0, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h8070_F0A5);
    run_txn(0, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h8070_F0A5);
    run_txn(0, 1, 3'b000, 32'h0000_0202, 32'h1234_56AB, 32'h0);
    run_txn(0, 1, 3'b001, 32'h0000_0202, 32'h1234_56AB, 32'h0);
    run_txn(0, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_2222);
    run_txn(0, 0, 3'b001, 32'h0000_0003, 32'h0, 32'h1111_2222);
    run_txn(0, 1, 3'b100, 32'h0000_0010, 32'hCAFE_F00D, 32'h0);
    run_txn(0, 0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h7654_3210);
    run_txn(1, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);

    // Back-to-back on the latency-3 unit with req_valid held high.
    model(0, 3'b010, 32'h0000_0300, 32'h0, 32'hA5A5_0F0F, err, be, mwd, res);
    wait_ready(1);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h0000_0300; mem_rdata[1] = 32'hA5A5_0F0F;
    rd_cnt = 0; rdy_cnt = 0;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 5 && mem_read[1]) rd_cnt++;
      if (c <= 4 && req_ready[1]) rdy_cnt++;
      if (c == 4) begin
        check("b2b_resp_valid", 32'(resp_valid[1]), 32'd1);
        check("b2b_resp_rdata", resp_rdata[1], res);
      end
      if (c == 5) check("b2b_ready_idle", 32'(req_ready[1]), 32'd1);
      if (c == 6) check("b2b_second_accept", 32'(mem_read[1]), 32'd1);
    end
    req_valid[1] = 1'b0;
    check("b2b_read_cycles", 32'(rd_cnt), 32'd3);
    check("b2b_ready_low", 32'(rdy_cnt), 32'd0);
    repeat (4) @(negedge clk);
    check("b2b_done_ready", 32'(req_ready[1]), 32'd1);

    // Reset in the second ACCESS cycle.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h0000_0400;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_read_before", 32'(mem_read[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", 32'(mem_read[1] | mem_write[1]), 32'd0);
    check("mid_rst_be", 32'(mem_be[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rst_ready", 32'(req_ready[1]), 32'd1);
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid[1]) rv_cnt++;
    end
    check("mid_rst_no_resp", 32'(rv_cnt), 32'd0);

    for (int i = 0; i < 120; i++) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(1) == 0) a[1:0] = 2'b00;
        run_txn(d, 1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
